// File: rtl/counter_button_sequencer.sv
// Front-panel button sequencer: synchronizes and debounces buttons, then
// issues one-hot strobes (with auto-repeat on inc) to the counter group.
module counter_button_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PULSE_CYCLES    = 4,
  parameter int GAP_CYCLES      = 4,
  parameter int HOLD_CYCLES     = 500000,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_clr,
  input  logic       sw_rev,
  output logic       selector,
  output logic       incrementor,
  output logic       clr,
  output logic       reverse,
  output logic       busy,
  output logic [7:0] event_cnt
);

  localparam logic [15:0] DB_M1  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  PLS_M1 = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0]  GAP_M1 = 8'(GAP_CYCLES - 1);
  localparam logic [23:0] HLD_M1 = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] REP_M1 = 24'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    RELEASE
  } state_t;

  // bit order everywhere: 0 sel, 1 inc, 2 clr, 3 rev
  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       deb_q, deb_d;
  logic [2:0]       prev_q, prev_d;
  logic [3:0][15:0] cnt_q, cnt_d;
  logic [2:0]       press;
  logic             src_lvl;

  state_t      state_q;
  logic [2:0]  src_q;
  logic [2:0]  strobe_q;
  logic        rev_q;
  logic        busy_q;
  logic        first_q;
  logic [7:0]  evt_q;
  logic [7:0]  pcnt_q;
  logic [23:0] timer_q;

  assign raw = {sw_rev, btn_clr, btn_inc, btn_sel};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    prev_d  = deb_q[2:0];
    cnt_d   = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_M1) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  // edge-based, so a level still high on return to IDLE never re-fires
  assign press   = deb_q[2:0] & ~prev_q;
  assign src_lvl = |(src_q & deb_q[2:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      strobe_q <= '0;
      rev_q    <= 1'b0;
      busy_q   <= 1'b0;
      first_q  <= 1'b1;
      evt_q    <= '0;
      pcnt_q   <= '0;
      timer_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|press) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
            rev_q   <= deb_q[3];
            if (press[2])      src_q <= 3'b100;
            else if (press[0]) src_q <= 3'b001;
            else               src_q <= 3'b010;
          end
        end
        SETUP: begin
          state_q  <= PULSE;
          strobe_q <= src_q;
          pcnt_q   <= '0;
          evt_q    <= evt_q + 8'd1;
        end
        PULSE: begin
          if (pcnt_q == PLS_M1) begin
            state_q  <= GAP;
            strobe_q <= '0;
            pcnt_q   <= '0;
          end else begin
            pcnt_q <= pcnt_q + 8'd1;
          end
        end
        GAP: begin
          if (pcnt_q == GAP_M1) begin
            state_q <= RELEASE;
            timer_q <= '0;
          end else begin
            pcnt_q <= pcnt_q + 8'd1;
          end
        end
        RELEASE: begin
          if (!src_lvl) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            first_q <= 1'b1;
          end else if (src_q[1]) begin
            if (timer_q == (first_q ? HLD_M1 : REP_M1)) begin
              state_q <= SETUP;
              rev_q   <= deb_q[3];
              first_q <= 1'b0;
            end else begin
              timer_q <= timer_q + 24'd1;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          strobe_q <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign selector    = strobe_q[0];
  assign incrementor = strobe_q[1];
  assign clr         = strobe_q[2];
  assign reverse     = rev_q;
  assign busy        = busy_q;
  assign event_cnt   = evt_q;

endmodule

// File: tb/tb_counter_button_sequencer.sv
// Directed bench for counter_button_sequencer with short timing parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_counter_button_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_clr = 1'b0;
  logic       sw_rev = 1'b0;
  logic       selector, incrementor, clr, reverse, busy;
  logic [7:0] event_cnt;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int sel_rise, inc_rise, clr_rise;
  int sel_hi, inc_hi, clr_hi, multi;
  int inc_at[$];
  logic sel_p, inc_p, clr_p;

  always #5 clk = ~clk;

  counter_button_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(3),
    .GAP_CYCLES(2),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_sel(btn_sel),
    .btn_inc(btn_inc),
    .btn_clr(btn_clr),
    .sw_rev(sw_rev),
    .selector(selector),
    .incrementor(incrementor),
    .clr(clr),
    .reverse(reverse),
    .busy(busy),
    .event_cnt(event_cnt)
  );

  task automatic clear_mon();
    sel_rise = 0; inc_rise = 0; clr_rise = 0;
    sel_hi = 0; inc_hi = 0; clr_hi = 0; multi = 0;
    inc_at.delete();
    sel_p = selector; inc_p = incrementor; clr_p = clr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (selector && !sel_p) sel_rise++;
      if (clr && !clr_p) clr_rise++;
      if (incrementor && !inc_p) begin
        inc_rise++;
        inc_at.push_back(cyc);
      end
      sel_hi += int'(selector);
      inc_hi += int'(incrementor);
      clr_hi += int'(clr);
      if (int'(selector) + int'(incrementor) + int'(clr) > 1) multi++;
      sel_p = selector; inc_p = incrementor; clr_p = clr;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    btn_sel = 1'b0; btn_inc = 1'b0; btn_clr = 1'b0; sw_rev = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(2);
    clear_mon();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({selector, incrementor, clr} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {selector, incrementor, clr});
    else passed++;
    total++;
    if (reverse !== 1'b0) $display("FAIL reset_reverse: got %b want 0", reverse);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else passed++;
    total++;
    if (event_cnt !== 8'd0) $display("FAIL reset_event_cnt: got %0d want 0", event_cnt);
    else passed++;
  endtask

  task automatic test_sel_single();
    apply_reset();
    btn_sel = 1'b1;
    run(7);
    total++;
    if ({selector, busy} !== 2'b01) $display("FAIL sel_setup: got sel/busy %b want 01", {selector, busy});
    else passed++;
    run(1);
    total++;
    if ({selector, event_cnt} !== {1'b1, 8'd1}) $display("FAIL sel_first_pulse: got sel=%b cnt=%0d want sel=1 cnt=1", selector, event_cnt);
    else passed++;
    run(32);
    btn_sel = 1'b0;
    run(20);
    total++;
    if (sel_rise !== 1 || sel_hi !== 3) $display("FAIL sel_pulse: got rises=%0d high=%0d want 1 3", sel_rise, sel_hi);
    else passed++;
    total++;
    if (inc_hi + clr_hi !== 0) $display("FAIL sel_other_strobes: got %0d want 0", inc_hi + clr_hi);
    else passed++;
    total++;
    if ({reverse, busy, event_cnt} !== {2'b00, 8'd1}) $display("FAIL sel_final: got rev=%b busy=%b cnt=%0d want 0 0 1", reverse, busy, event_cnt);
    else passed++;
  endtask

  task automatic test_bounce();
    int lv[8];
    int ln[8];
    int base;
    lv = '{1, 0, 1, 0, 1, 0, 1, 0};
    ln = '{2, 1, 3, 2, 1, 3, 2, 1};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      btn_inc = lv[i][0];
      run(ln[i]);
    end
    run(0);
    total++;
    if (inc_hi !== 0 || busy !== 1'b0) $display("FAIL bounce_quiet: got inc_high=%0d busy=%b want 0 0", inc_hi, busy);
    else passed++;
    btn_inc = 1'b1;
    base = cyc;
    run(20);
    btn_inc = 1'b0;
    run(20);
    total++;
    if (inc_rise !== 1 || inc_hi !== 3) $display("FAIL bounce_pulse: got rises=%0d high=%0d want 1 3", inc_rise, inc_hi);
    else passed++;
    total++;
    if (inc_at.size() < 1 || inc_at[0] - base !== 8) $display("FAIL bounce_latency: got %0d want 8", inc_at.size() > 0 ? inc_at[0] - base : -1);
    else passed++;
  endtask

  task automatic test_inc_repeat();
    int expo[4];
    int base;
    int got;
    expo = '{8, 34, 50, 66};
    apply_reset();
    btn_inc = 1'b1;
    base = cyc;
    run(60);
    btn_inc = 1'b0;
    run(30);
    total++;
    if (inc_rise !== 4 || inc_hi !== 12) $display("FAIL repeat_count: got rises=%0d high=%0d want 4 12", inc_rise, inc_hi);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      got = (i < inc_at.size()) ? inc_at[i] - base : -1;
      total++;
      if (got !== expo[i]) $display("FAIL repeat_time_%0d: got %0d want %0d", i, got, expo[i]);
      else passed++;
    end
    total++;
    if (event_cnt !== 8'd4 || busy !== 1'b0) $display("FAIL repeat_final: got cnt=%0d busy=%b want 4 0", event_cnt, busy);
    else passed++;
  endtask

  task automatic test_coincident();
    apply_reset();
    btn_clr = 1'b1;
    btn_sel = 1'b1;
    run(15);
    btn_clr = 1'b0;
    run(25);
    btn_sel = 1'b0;
    run(20);
    total++;
    if (clr_rise !== 1 || clr_hi !== 3) $display("FAIL coinc_clr: got rises=%0d high=%0d want 1 3", clr_rise, clr_hi);
    else passed++;
    total++;
    if (sel_rise !== 0 || event_cnt !== 8'd1) $display("FAIL coinc_sel_dropped: got sel_rises=%0d cnt=%0d want 0 1", sel_rise, event_cnt);
    else passed++;
    btn_sel = 1'b1;
    run(15);
    btn_sel = 1'b0;
    run(20);
    total++;
    if (sel_rise !== 1 || event_cnt !== 8'd2) $display("FAIL coinc_sel_repress: got sel_rises=%0d cnt=%0d want 1 2", sel_rise, event_cnt);
    else passed++;
  endtask

  task automatic test_rev_during_pulse();
    apply_reset();
    btn_sel = 1'b1;
    run(8);
    sw_rev = 1'b1;
    run(1);
    total++;
    if ({selector, reverse} !== 2'b10) $display("FAIL rev_in_pulse: got sel/rev %b want 10", {selector, reverse});
    else passed++;
    run(4);
    total++;
    if (reverse !== 1'b0) $display("FAIL rev_in_gap: got %b want 0", reverse);
    else passed++;
    btn_sel = 1'b0;
    run(20);
    total++;
    if (reverse !== 1'b0 || busy !== 1'b0) $display("FAIL rev_idle_hold: got rev=%b busy=%b want 0 0", reverse, busy);
    else passed++;
    btn_inc = 1'b1;
    run(7);
    total++;
    if (reverse !== 1'b1) $display("FAIL rev_next_setup: got %b want 1", reverse);
    else passed++;
    btn_inc = 1'b0;
    run(25);
    total++;
    if (multi !== 0) $display("FAIL onehot: got %0d overlapping cycles want 0", multi);
    else passed++;
  endtask

  task automatic test_reset_mid_pulse();
    int base;
    apply_reset();
    btn_inc = 1'b1;
    run(9);
    total++;
    if (incrementor !== 1'b1 || event_cnt !== 8'd1) $display("FAIL rst_pre: got inc=%b cnt=%0d want 1 1", incrementor, event_cnt);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if (incrementor !== 1'b0) $display("FAIL rst_truncate: got %b want 0", incrementor);
    else passed++;
    total++;
    if ({selector, clr, reverse, busy, event_cnt} !== 12'd0) $display("FAIL rst_outputs: got sel=%b clr=%b rev=%b busy=%b cnt=%0d want all 0", selector, clr, reverse, busy, event_cnt);
    else passed++;
    run(2);
    clear_mon();
    reset_n = 1'b1;
    base = cyc;
    run(20);
    btn_inc = 1'b0;
    run(20);
    total++;
    if (inc_rise !== 1 || event_cnt !== 8'd1) $display("FAIL rst_held_press: got rises=%0d cnt=%0d want 1 1", inc_rise, event_cnt);
    else passed++;
    total++;
    if (inc_at.size() < 1 || inc_at[0] - base !== 8) $display("FAIL rst_held_latency: got %0d want 8", inc_at.size() > 0 ? inc_at[0] - base : -1);
    else passed++;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_sel_single();
    test_bounce();
    test_inc_repeat();
    test_coincident();
    test_rev_during_pulse();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
